// File: rtl/bus8_arbiter.sv
// bus8_arbiter: two-master round-robin arbiter for the 8-bit register bus with read routing and read timeout.
module bus8_arbiter #(
  parameter int RD_TIMEOUT = 255,
  parameter logic [7:0] TIMEOUT_DATA = 8'hEE
) (
  input  logic        i_Bus_Clk,
  input  logic        i_Bus_Rst,
  input  logic        i_M0_CS,
  input  logic        i_M0_Wr_Rd_n,
  input  logic [15:0] i_M0_Addr8,
  input  logic [7:0]  i_M0_Wr_Data,
  output logic [7:0]  o_M0_Rd_Data,
  output logic        o_M0_Rd_DV,
  output logic        o_M0_Rd_Err,
  output logic        o_M0_Busy,
  input  logic        i_M1_CS,
  input  logic        i_M1_Wr_Rd_n,
  input  logic [15:0] i_M1_Addr8,
  input  logic [7:0]  i_M1_Wr_Data,
  output logic [7:0]  o_M1_Rd_Data,
  output logic        o_M1_Rd_DV,
  output logic        o_M1_Rd_Err,
  output logic        o_M1_Busy,
  output logic        o_Bus_CS,
  output logic        o_Bus_Wr_Rd_n,
  output logic [15:0] o_Bus_Addr8,
  output logic [7:0]  o_Bus_Wr_Data,
  input  logic [7:0]  i_Bus_Rd_Data,
  input  logic        i_Bus_Rd_DV
);
  localparam int CW = $clog2(RD_TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, RD_WAIT} state_t;
  state_t state;
  logic [1:0] busy, wr, rd_dv, rd_err;
  logic [1:0][15:0] addr;
  logic [1:0][7:0] wdat, rd_data;
  logic last, cur, gnt;
  logic [CW-1:0] cnt;
  logic [1:0] cs_in, wr_in;
  logic [1:0][15:0] addr_in;
  logic [1:0][7:0] dat_in;
  assign cs_in = {i_M1_CS, i_M0_CS};
  assign wr_in = {i_M1_Wr_Rd_n, i_M0_Wr_Rd_n};
  assign addr_in = {i_M1_Addr8, i_M0_Addr8};
  assign dat_in = {i_M1_Wr_Data, i_M0_Wr_Data};
  // with both pending the master not granted last wins
  assign gnt = &busy ? ~last : busy[1];
  assign o_M0_Busy = busy[0];
  assign o_M1_Busy = busy[1];
  assign o_M0_Rd_DV = rd_dv[0];
  assign o_M1_Rd_DV = rd_dv[1];
  assign o_M0_Rd_Err = rd_err[0];
  assign o_M1_Rd_Err = rd_err[1];
  assign o_M0_Rd_Data = rd_data[0];
  assign o_M1_Rd_Data = rd_data[1];
  always_ff @(posedge i_Bus_Clk) begin
    if (i_Bus_Rst) begin
      state <= IDLE;
      busy <= '0;
      wr <= '0;
      addr <= '0;
      wdat <= '0;
      rd_dv <= '0;
      rd_err <= '0;
      rd_data <= '0;
      last <= 1'b1;
      cur <= 1'b0;
      cnt <= '0;
      o_Bus_CS <= 1'b0;
      o_Bus_Wr_Rd_n <= 1'b0;
      o_Bus_Addr8 <= '0;
      o_Bus_Wr_Data <= '0;
    end else begin
      o_Bus_CS <= 1'b0;
      rd_dv <= '0;
      rd_err <= '0;
      for (int i = 0; i < 2; i++)
        if (cs_in[i] && !busy[i]) begin
          busy[i] <= 1'b1;
          wr[i] <= wr_in[i];
          addr[i] <= addr_in[i];
          wdat[i] <= dat_in[i];
        end
      case (state)
        IDLE:
          if (|busy) begin
            last <= gnt;
            cur <= gnt;
            o_Bus_CS <= 1'b1;
            o_Bus_Wr_Rd_n <= wr[gnt];
            o_Bus_Addr8 <= addr[gnt];
            o_Bus_Wr_Data <= wdat[gnt];
            state <= ISSUE;
          end
        ISSUE:
          if (wr[cur]) begin
            busy[cur] <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= '0;
            state <= RD_WAIT;
          end
        RD_WAIT:
          if (i_Bus_Rd_DV || cnt == CW'(RD_TIMEOUT - 1)) begin
            rd_data[cur] <= i_Bus_Rd_DV ? i_Bus_Rd_Data : TIMEOUT_DATA;
            rd_dv[cur] <= 1'b1;
            rd_err[cur] <= !i_Bus_Rd_DV;
            busy[cur] <= 1'b0;
            state <= IDLE;
          end else cnt <= cnt + CW'(1);
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bus8_arbiter.sv
// tb_bus8_arbiter: directed and random stimulus against a cycle-count transaction model of bus8_arbiter.
module tb_bus8_arbiter;
  localparam int T = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic cs_v[2], wr_v[2];
  logic [15:0] a_v[2];
  logic [7:0] d_v[2];
  logic rd_dv_in;
  logic [7:0] rd_data_in;
  logic [7:0] o_M0_Rd_Data, o_M1_Rd_Data, o_Bus_Wr_Data;
  logic o_M0_Rd_DV, o_M0_Rd_Err, o_M0_Busy, o_M1_Rd_DV, o_M1_Rd_Err, o_M1_Busy;
  logic o_Bus_CS, o_Bus_Wr_Rd_n;
  logic [15:0] o_Bus_Addr8;
  int c = 0, comps = 0, fails = 0, cs_count = 0;
  int f_lat = 0, f_dat = -1;
  // transaction model: pending slots plus cycle numbers of the current grant's events
  bit mvalid = 0, last, cur_rd, to_err;
  bit m_busy[2], nb[2], s_wr[2];
  logic [15:0] s_a[2];
  logic [7:0] s_d[2], rsp;
  int owner, free_at, cs_cyc = -1, done = -1, dv_cyc = -1, lat;
  bit e_cs, e_wr, e_dv[2], e_err[2];
  logic [15:0] e_addr;
  logic [7:0] e_wd, e_rdd[2];

  always #5 clk = ~clk;

  bus8_arbiter #(.RD_TIMEOUT(T), .TIMEOUT_DATA(8'hEE)) dut (
    .i_Bus_Clk(clk), .i_Bus_Rst(rst),
    .i_M0_CS(cs_v[0]), .i_M0_Wr_Rd_n(wr_v[0]), .i_M0_Addr8(a_v[0]), .i_M0_Wr_Data(d_v[0]),
    .o_M0_Rd_Data(o_M0_Rd_Data), .o_M0_Rd_DV(o_M0_Rd_DV), .o_M0_Rd_Err(o_M0_Rd_Err), .o_M0_Busy(o_M0_Busy),
    .i_M1_CS(cs_v[1]), .i_M1_Wr_Rd_n(wr_v[1]), .i_M1_Addr8(a_v[1]), .i_M1_Wr_Data(d_v[1]),
    .o_M1_Rd_Data(o_M1_Rd_Data), .o_M1_Rd_DV(o_M1_Rd_DV), .o_M1_Rd_Err(o_M1_Rd_Err), .o_M1_Busy(o_M1_Busy),
    .o_Bus_CS(o_Bus_CS), .o_Bus_Wr_Rd_n(o_Bus_Wr_Rd_n), .o_Bus_Addr8(o_Bus_Addr8), .o_Bus_Wr_Data(o_Bus_Wr_Data),
    .i_Bus_Rd_Data(rd_data_in), .i_Bus_Rd_DV(rd_dv_in)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    comps++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h want %h (cycle %0d)", tag, obs, exp, c);
    end
  endtask

  task automatic model_step();
    if (rst) begin
      m_busy = '{0, 0};
      last = 1;
      free_at = c + 1;
      cs_cyc = -1;
      done = -1;
      dv_cyc = -1;
      e_cs = 0; e_wr = 0; e_addr = '0; e_wd = '0;
      e_dv = '{0, 0}; e_err = '{0, 0}; e_rdd = '{8'h00, 8'h00};
      mvalid = 1;
    end else begin
      nb = m_busy;
      for (int x = 0; x < 2; x++)
        if (cs_v[x] && !m_busy[x]) begin
          nb[x] = 1;
          s_wr[x] = wr_v[x];
          s_a[x] = a_v[x];
          s_d[x] = d_v[x];
        end
      if (c + 1 == done) nb[owner] = 0;
      if (c >= free_at && (m_busy[0] || m_busy[1])) begin
        owner = (m_busy[0] && m_busy[1]) ? (last ? 0 : 1) : (m_busy[1] ? 1 : 0);
        last = (owner == 1);
        cs_cyc = c + 1;
        e_wr = s_wr[owner];
        e_addr = s_a[owner];
        e_wd = s_d[owner];
        cur_rd = !s_wr[owner];
        if (!cur_rd) done = c + 2;
        else begin
          lat = f_lat > 0 ? f_lat : $urandom_range(1, T + 2);
          rsp = f_dat >= 0 ? 8'(f_dat) : 8'($urandom);
          dv_cyc = c + 1 + lat;
          to_err = lat > T;
          done = to_err ? c + 2 + T : c + 2 + lat;
        end
        free_at = done;
      end
      m_busy = nb;
      e_cs = (c + 1 == cs_cyc);
      for (int x = 0; x < 2; x++) begin
        e_dv[x] = (c + 1 == done) && cur_rd && owner == x;
        e_err[x] = e_dv[x] && to_err;
        if (e_dv[x]) e_rdd[x] = to_err ? 8'hEE : rsp;
      end
    end
  endtask

  task automatic tick();
    rd_dv_in = (c == dv_cyc);
    rd_data_in = rd_dv_in ? rsp : 8'($urandom);
    @(negedge clk);
    if (o_Bus_CS) cs_count++;
    if (mvalid) begin
      chk("busy0", o_M0_Busy, m_busy[0]);
      chk("busy1", o_M1_Busy, m_busy[1]);
      chk("bus_cs", o_Bus_CS, e_cs);
      chk("bus_dir", o_Bus_Wr_Rd_n, e_wr);
      chk("bus_addr", o_Bus_Addr8, e_addr);
      chk("bus_wdata", o_Bus_Wr_Data, e_wd);
      chk("rd_dv0", o_M0_Rd_DV, e_dv[0]);
      chk("rd_dv1", o_M1_Rd_DV, e_dv[1]);
      chk("rd_err0", o_M0_Rd_Err, e_err[0]);
      chk("rd_err1", o_M1_Rd_Err, e_err[1]);
      chk("rd_data0", o_M0_Rd_Data, e_rdd[0]);
      chk("rd_data1", o_M1_Rd_Data, e_rdd[1]);
    end
    model_step();
    @(posedge clk);
    #1;
    c++;
    cs_v[0] = 0;
    cs_v[1] = 0;
    rst = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic req(input int x, input logic w, input logic [15:0] a, input logic [7:0] d);
    cs_v[x] = 1;
    wr_v[x] = w;
    a_v[x] = a;
    d_v[x] = d;
  endtask

  initial begin
    cs_v = '{0, 0}; wr_v = '{0, 0}; a_v = '{16'h0, 16'h0}; d_v = '{8'h0, 8'h0};
    rd_dv_in = 0; rd_data_in = '0;
    #1;
    rst = 1; tick();
    rst = 1; tick();
    chk("rst_cs", o_Bus_CS, 0);
    chk("rst_addr", o_Bus_Addr8, 0);
    chk("rst_busy", {o_M1_Busy, o_M0_Busy}, 0);
    // single write
    req(0, 1, 16'h0014, 8'h5A); tick();
    chk("wr_busy", o_M0_Busy, 1);
    tick();
    chk("wr_cs", o_Bus_CS, 1);
    chk("wr_addr", o_Bus_Addr8, 16'h0014);
    chk("wr_data", o_Bus_Wr_Data, 8'h5A);
    chk("wr_dir", o_Bus_Wr_Rd_n, 1);
    tick();
    chk("wr_done", o_M0_Busy, 0);
    idle(2);
    // single read, slave answers 3 cycles after CS
    f_lat = 3; f_dat = 8'h3C;
    req(1, 0, 16'h0003, 8'h00); idle(6);
    chk("rd1_dv", o_M1_Rd_DV, 1);
    chk("rd1_data", o_M1_Rd_Data, 8'h3C);
    chk("rd1_err", o_M1_Rd_Err, 0);
    chk("rd1_dv0", o_M0_Rd_DV, 0);
    idle(2);
    // ties: M0 then M1, twice
    for (int r = 0; r < 2; r++) begin
      req(0, 1, 16'h1000 + 16'(r), 8'h11);
      req(1, 1, 16'h2000 + 16'(r), 8'h22);
      idle(2);
      chk("tie_cs_a", o_Bus_CS, 1);
      chk("tie_addr_a", o_Bus_Addr8, 16'h1000 + 16'(r));
      tick();
      chk("tie_gap", o_Bus_CS, 0);
      tick();
      chk("tie_cs_b", o_Bus_CS, 1);
      chk("tie_addr_b", o_Bus_Addr8, 16'h2000 + 16'(r));
      tick();
    end
    idle(2);
    // timeout with a late answer one cycle after the error pulse
    f_lat = T + 2; f_dat = -1;
    req(0, 0, 16'h0042, 8'h00); idle(7);
    chk("to_dv", o_M0_Rd_DV, 1);
    chk("to_err", o_M0_Rd_Err, 1);
    chk("to_data", o_M0_Rd_Data, 8'hEE);
    idle(2);
    chk("late_dv", o_M0_Rd_DV, 0);
    chk("late_data", o_M0_Rd_Data, 8'hEE);
    chk("late_busy", o_M0_Busy, 0);
    idle(2);
    // requests while busy are dropped
    f_lat = 2; cs_count = 0;
    req(0, 0, 16'h0050, 8'h00); tick();
    req(0, 1, 16'h0099, 8'h99); tick();
    req(0, 1, 16'h0099, 8'h99); idle(9);
    chk("drop_cs_count", 16'(cs_count), 1);
    // reset in the middle of a read
    f_lat = T + 2;
    req(0, 0, 16'h0060, 8'h00); idle(4);
    rst = 1; tick();
    chk("mrst_cs", o_Bus_CS, 0);
    chk("mrst_busy", o_M0_Busy, 0);
    chk("mrst_rdd", o_M0_Rd_Data, 0);
    chk("mrst_addr", o_Bus_Addr8, 0);
    idle(8);
    req(1, 1, 16'h0077, 8'h77); idle(2);
    chk("post_rst_cs", o_Bus_CS, 1);
    chk("post_rst_addr", o_Bus_Addr8, 16'h0077);
    idle(3);
    // random traffic
    f_lat = 0; f_dat = -1;
    for (int i = 0; i < 2000; i++) begin
      for (int x = 0; x < 2; x++)
        if ($urandom_range(0, 3) == 0) req(x, 1'($urandom), 16'($urandom), 8'($urandom));
      rst = ($urandom_range(0, 399) == 0);
      tick();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", comps, fails);
    $finish;
  end
endmodule
